// File: rtl/semafor_pkg.sv
// Shared types for the car/pedestrian traffic-light controller.
// State codes, lamp bundle, timer width and the lamp decoder.
package semafor_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_CG    = 3'd1,
        S_CY    = 3'd2,
        S_AR1   = 3'd3,
        S_PG    = 3'd4,
        S_PB    = 3'd5,
        S_AR2   = 3'd6,
        S_NIGHT = 3'd7
    } state_t;

    typedef struct packed {
        logic car_red;
        logic car_yellow;
        logic car_green;
        logic ped_red;
        logic ped_green;
    } lamps_t;

    localparam lamps_t LAMPS_RESET = 5'b10010;

    // ph is bit 0 of the state timer: 0 on the first tick
    // of a state, so blinking lamps start lit.
    function automatic lamps_t lamp_decode(
        input state_t s,
        input logic   ph
    );
        lamps_t l;
        l = '0;
        unique case (s)
            S_CG: begin
                l.car_green = 1'b1;
                l.ped_red   = 1'b1;
            end
            S_CY: begin
                l.car_yellow = 1'b1;
                l.ped_red    = 1'b1;
            end
            S_PG: begin
                l.car_red   = 1'b1;
                l.ped_green = 1'b1;
            end
            S_PB: begin
                l.car_red   = 1'b1;
                l.ped_green = ~ph;
            end
            S_NIGHT: begin
                l.car_yellow = ~ph;
            end
            default: begin
                l.car_red = 1'b1;
                l.ped_red = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semafor_tick_gen.sv
// Prescaler producing a one-clk tick every TICK_DIV clocks.
// Ports: clk, rst_n (async, active low) -> tick.
module semafor_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/semafor_ctrl.sv
// Traffic-light controller: one car lane, one pedestrian crossing,
// latched pedestrian requests and a flashing night mode.
// Ports: clk, rst_n (async, active low), ped_req, night in;
//        car_red/yellow/green, ped_red/green, ped_wait, state_o out.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int TICK_DIV    = 10,
    parameter int T_MIN_GREEN = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_PED       = 6,
    parameter int T_BLINK     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       night,
    output logic       car_red,
    output logic       car_yellow,
    output logic       car_green,
    output logic       ped_red,
    output logic       ped_green,
    output logic       ped_wait,
    output logic [2:0] state_o
);

    typedef logic [TIMER_W-1:0] tmr_t;

    localparam tmr_t L_MG  = tmr_t'(T_MIN_GREEN - 1);
    localparam tmr_t SAT   = tmr_t'(T_MIN_GREEN);
    localparam tmr_t L_Y   = tmr_t'(T_YELLOW - 1);
    localparam tmr_t L_AR  = tmr_t'(T_ALLRED - 1);
    localparam tmr_t L_PED = tmr_t'(T_PED - 1);
    localparam tmr_t L_BL  = tmr_t'(T_BLINK - 1);

    logic   tick;
    state_t state_q, state_d;
    tmr_t   timer_q, timer_d;
    logic   pw_q, pw_d;
    lamps_t lamps_q, lamps_d;

    semafor_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            timer_q <= '0;
            pw_q    <= 1'b0;
            lamps_q <= LAMPS_RESET;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pw_q    <= pw_d;
            lamps_q <= lamps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pw_d    = pw_q;

        if (ped_req && state_q != S_PG
                    && state_q != S_PB) begin
            pw_d = 1'b1;
        end

        if (tick) begin
            timer_d = timer_q + 1'b1;
            unique case (state_q)
                S_INIT: begin
                    if (timer_q == L_AR) state_d = S_CG;
                end
                S_CG: begin
                    // Hold at SAT so a long green never wraps
                    if (timer_q == SAT) timer_d = SAT;
                    if (timer_q >= L_MG) begin
                        if (night)     state_d = S_NIGHT;
                        else if (pw_q) state_d = S_CY;
                    end
                end
                S_CY: begin
                    if (timer_q == L_Y) state_d = S_AR1;
                end
                S_AR1: begin
                    if (timer_q == L_AR) state_d = S_PG;
                end
                S_PG: begin
                    if (timer_q == L_PED) state_d = S_PB;
                end
                S_PB: begin
                    if (timer_q == L_BL) state_d = S_AR2;
                end
                S_AR2: begin
                    if (timer_q == L_AR) state_d = S_CG;
                end
                S_NIGHT: begin
                    if (!night) state_d = S_INIT;
                end
                default: state_d = S_INIT;
            endcase
            if (state_d != state_q) timer_d = '0;
        end

        // Entering the walk phase serves the pending request
        if (state_d == S_PG && state_q != S_PG) begin
            pw_d = 1'b0;
        end

        lamps_d = lamp_decode(state_d, timer_d[0]);
    end

    assign car_red    = lamps_q.car_red;
    assign car_yellow = lamps_q.car_yellow;
    assign car_green  = lamps_q.car_green;
    assign ped_red    = lamps_q.ped_red;
    assign ped_green  = lamps_q.ped_green;
    assign ped_wait   = pw_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Directed bench for semafor_ctrl with TICK_DIV=2.
// Times are posedges counted since the last reset release.
module tb_semafor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic       car_red, car_yellow, car_green;
    logic       ped_red, ped_green, ped_wait;
    logic [2:0] state_o;

    int vecs = 0;
    int errs = 0;
    int t;

    semafor_ctrl #(
        .TICK_DIV (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_req    (ped_req),
        .night      (night),
        .car_red    (car_red),
        .car_yellow (car_yellow),
        .car_green  (car_green),
        .ped_red    (ped_red),
        .ped_green  (ped_green),
        .ped_wait   (ped_wait),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(car_green && ped_green))
            else begin
                errs++;
                $error("FAIL safety t=%0d cg=%b pg=%b",
                       t, car_green, ped_green);
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s t=%0d obs=%0h exp=%0h",
                   tag, t, obs, exp);
        end
    endtask

    task automatic at(input int n);
        int guard;
        guard = 0;
        while (t < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (t != n) chk("timebase", 8'(t), 8'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_req();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    // lamp vector {cr,cy,cg,pr,pg}
    function automatic logic [7:0] lv();
        return {3'b0, car_red, car_yellow, car_green,
                ped_red, ped_green};
    endfunction

    initial begin
        // 1: reset values, first green 4 clk after release
        @(negedge clk);
        chk("rst_lamps", lv(), 8'b10010);
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_wait", 8'(ped_wait), 8'd0);
        rst_n = 1'b1;
        at(3);
        chk("init_hold", 8'(state_o), 8'd0);
        chk("init_cg0", 8'(car_green), 8'd0);
        at(4);
        chk("first_cg", lv(), 8'b00110);
        chk("first_st", 8'(state_o), 8'd1);

        // 2: idle green holds
        at(1004);
        chk("idle_st", 8'(state_o), 8'd1);
        chk("idle_cg", 8'(car_green), 8'd1);
        chk("idle_wait", 8'(ped_wait), 8'd0);

        // 3: one pedestrian cycle
        do_reset();
        at(8);
        pulse_req();
        chk("req_latch", 8'(ped_wait), 8'd1);
        at(18);
        chk("cg_min", 8'(state_o), 8'd1);
        at(20);
        chk("cy_st", 8'(state_o), 8'd2);
        chk("cy_lamps", lv(), 8'b01010);
        at(24);
        chk("cy_hold", 8'(state_o), 8'd2);
        at(26);
        chk("ar1_st", 8'(state_o), 8'd3);
        chk("ar1_lamps", lv(), 8'b10010);
        at(30);
        chk("pg_st", 8'(state_o), 8'd4);
        chk("pg_lamps", lv(), 8'b10001);
        chk("pg_wait", 8'(ped_wait), 8'd0);
        at(40);
        chk("pg_hold", 8'(state_o), 8'd4);
        at(42);
        chk("pb_st", 8'(state_o), 8'd5);
        chk("pb_g1", 8'(ped_green), 8'd1);
        at(44);
        chk("pb_g2", 8'(ped_green), 8'd0);
        at(46);
        chk("pb_g3", 8'(ped_green), 8'd1);
        at(48);
        chk("pb_g4", 8'(ped_green), 8'd0);
        at(50);
        chk("ar2_st", 8'(state_o), 8'd6);
        chk("ar2_lamps", lv(), 8'b10010);
        at(54);
        chk("back_cg", lv(), 8'b00110);
        chk("back_st", 8'(state_o), 8'd1);

        // 4: night mode
        night = 1'b1;
        at(68);
        chk("nt_min", 8'(state_o), 8'd1);
        at(70);
        chk("nt_st", 8'(state_o), 8'd7);
        chk("nt_y1", lv(), 8'b01000);
        at(72);
        chk("nt_y2", lv(), 8'b00000);
        at(74);
        chk("nt_y3", lv(), 8'b01000);
        night = 1'b0;
        at(76);
        chk("nt_init", 8'(state_o), 8'd0);
        chk("nt_init_l", lv(), 8'b10010);
        at(78);
        chk("nt_init2", 8'(state_o), 8'd0);
        at(80);
        chk("nt_cg", 8'(state_o), 8'd1);

        // 5: ignored requests, night beats pending walk
        pulse_req();
        at(96);
        chk("c5_cy", 8'(state_o), 8'd2);
        at(108);
        chk("c5_pg", 8'(state_o), 8'd4);
        pulse_req();
        chk("pg_ignore", 8'(ped_wait), 8'd0);
        at(120);
        chk("c5_pb", 8'(state_o), 8'd5);
        pulse_req();
        chk("pb_ignore", 8'(ped_wait), 8'd0);
        at(130);
        chk("c5_cg", 8'(state_o), 8'd1);
        night = 1'b1;
        pulse_req();
        chk("c5_wait", 8'(ped_wait), 8'd1);
        at(144);
        chk("c5_cgmin", 8'(state_o), 8'd1);
        at(146);
        chk("c5_night", 8'(state_o), 8'd7);
        chk("c5_wait_n", 8'(ped_wait), 8'd1);
        night = 1'b0;
        at(148);
        chk("c5_init", 8'(state_o), 8'd0);
        at(152);
        chk("c5_cg2", 8'(state_o), 8'd1);
        at(166);
        chk("c5_cg2min", 8'(state_o), 8'd1);
        at(168);
        chk("c5_cy2", 8'(state_o), 8'd2);
        at(178);
        chk("c5_pg2", 8'(state_o), 8'd4);
        chk("c5_served", 8'(ped_wait), 8'd0);

        // 6: async reset in the middle of walk
        at(180);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_lamps", lv(), 8'b10010);
        chk("ar_state", 8'(state_o), 8'd0);
        chk("ar_wait", 8'(ped_wait), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        at(4);
        chk("ar_cg", lv(), 8'b00110);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
